// File: rtl/pmod_jstk_responder.sv
// pmod_jstk_responder: PmodJSTK-side SPI slave answering the 5-byte joystick frame.
// Reports X/Y/buttons on MISO and decodes the LED command byte from MOSI. Rev 1.0
`default_nettype none

module pmod_jstk_responder #(
   parameter logic [5:0] CMD_PREFIX = 6'b100000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   input  logic [2:0] btn,
   input  logic       SS,
   input  logic       SCLK,
   input  logic       MOSI,
   output logic       MISO,
   output logic [1:0] led_cmd,
   output logic       cmd_valid,
   output logic       busy,
   output logic       frame_done,
   output logic       frame_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [2:0]  ss_sync;
   logic [2:0]  sclk_sync;
   logic [1:0]  mosi_sync;
   logic        ss_fall;
   logic        ss_rise;
   logic        sclk_rise;
   logic        sclk_fall;
   logic        mosi_s;

   logic [38:0] tx;
   logic [7:0]  rx;
   logic [5:0]  bit_cnt;
   logic [39:0] frame_word;
   logic [7:0]  rx_next;

   // Syncs clear to 0 so a reset with SS held low never fakes a falling edge.
   always_ff @(posedge clk) begin
      if (clr) begin
         ss_sync   <= 3'b000;
         sclk_sync <= 3'b000;
         mosi_sync <= 2'b00;
      end else begin
         ss_sync   <= {ss_sync[1:0], SS};
         sclk_sync <= {sclk_sync[1:0], SCLK};
         mosi_sync <= {mosi_sync[0], MOSI};
      end
   end

   assign ss_fall   = ~ss_sync[1] &  ss_sync[2];
   assign ss_rise   =  ss_sync[1] & ~ss_sync[2];
   assign sclk_rise =  sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall = ~sclk_sync[1] &  sclk_sync[2];
   assign mosi_s    =  mosi_sync[1];

   assign frame_word = {x_pos[7:0], 6'b0, x_pos[9:8],
                        y_pos[7:0], 6'b0, y_pos[9:8],
                        5'b0, btn};
   assign rx_next    = {rx[6:0], mosi_s};

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      frame_done = 1'b0;
      frame_err  = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            busy       = 1'b1;
            state_next = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (ss_rise) begin
               state_next = DONE;
            end
         end
         DONE: begin
            frame_done = (bit_cnt == 6'd40);
            frame_err  = (bit_cnt != 6'd40);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         tx        <= '0;
         rx        <= '0;
         bit_cnt   <= '0;
         MISO      <= 1'b0;
         led_cmd   <= 2'b00;
         cmd_valid <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         case (state)
            LOAD: begin
               tx      <= frame_word[38:0];
               MISO    <= frame_word[39];
               rx      <= '0;
               bit_cnt <= '0;
            end
            SHIFT: begin
               // A coincident SS rise wins; the SCLK edge is dropped.
               if (!ss_rise) begin
                  if (sclk_rise) begin
                     rx <= rx_next;
                     if (bit_cnt != 6'd63) begin
                        bit_cnt <= bit_cnt + 6'd1;
                     end
                     if (bit_cnt >= 6'd39) begin
                        MISO <= 1'b0;
                     end
                     if ((bit_cnt == 6'd7) && (rx_next[7:2] == CMD_PREFIX)) begin
                        led_cmd   <= rx_next[1:0];
                        cmd_valid <= 1'b1;
                     end
                  end else if (sclk_fall) begin
                     if (bit_cnt < 6'd40) begin
                        tx   <= {tx[37:0], 1'b0};
                        MISO <= tx[38];
                     end else begin
                        MISO <= 1'b0;
                     end
                  end
               end
            end
            default: MISO <= 1'b0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pmod_jstk_responder.sv
// tb_pmod_jstk_responder: directed SPI-master bench for pmod_jstk_responder.
`default_nettype none

module tb_pmod_jstk_responder;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [9:0] x_pos = '0;
   logic [9:0] y_pos = '0;
   logic [2:0] btn = '0;
   logic       SS = 1'b1;
   logic       SCLK = 1'b0;
   logic       MOSI = 1'b0;
   logic       MISO;
   logic [1:0] led_cmd;
   logic       cmd_valid;
   logic       busy;
   logic       frame_done;
   logic       frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int n_cmd = 0;
   int n_done = 0;
   int n_err = 0;

   pmod_jstk_responder #(.CMD_PREFIX(6'b100000)) dut (
      .clk(clk), .clr(clr), .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
      .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .led_cmd(led_cmd),
      .cmd_valid(cmd_valid), .busy(busy), .frame_done(frame_done),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Counting per high cycle also catches pulses wider than one cycle.
   always @(negedge clk) begin
      if (cmd_valid)  n_cmd  <= n_cmd + 1;
      if (frame_done) n_done <= n_done + 1;
      if (frame_err)  n_err  <= n_err + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Mode-0 master at 1 MHz (50 clk half period); MISO sampled at each SCLK rise.
   task automatic spi_frame(input logic [7:0] b0, input int nbits,
                            input int chg_bit, input logic [9:0] chg_x,
                            input int rst_bit,
                            output logic [47:0] rx_bits, output logic busy_mid);
      logic [7:0] sh;
      sh       = b0;
      rx_bits  = '0;
      busy_mid = 1'b0;
      SS   = 1'b0;
      MOSI = sh[7];
      wait_clk(50);
      for (int i = 0; i < nbits; i++) begin
         if (i == chg_bit) x_pos = chg_x;
         if (i == rst_bit) begin
            clr = 1'b1;
            wait_clk(1);
            clr = 1'b0;
            check("rst_mid_miso", 64'(MISO), 64'd0);
            check("rst_mid_busy", 64'(busy), 64'd0);
            check("rst_mid_led", 64'(led_cmd), 64'd0);
         end
         if (i == 20) busy_mid = busy;
         SCLK = 1'b1;
         rx_bits[47-i] = MISO;
         wait_clk(50);
         SCLK = 1'b0;
         sh   = {sh[6:0], 1'b0};
         MOSI = sh[7];
         wait_clk(50);
      end
      SS = 1'b1;
      wait_clk(20);
   endtask

   logic [47:0] got;
   logic        bm;
   int          c0, d0, e0;

   task automatic snap();
      c0 = n_cmd;
      d0 = n_done;
      e0 = n_err;
   endtask

   initial begin
      wait_clk(4);
      clr = 1'b0;
      check("reset_miso", 64'(MISO), 64'd0);
      check("reset_led", 64'(led_cmd), 64'd0);
      check("reset_cmd_valid", 64'(cmd_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(frame_done), 64'd0);
      check("reset_err", 64'(frame_err), 64'd0);
      wait_clk(10);

      // Nominal frame with LED command 0x83
      x_pos = 10'h2A5; y_pos = 10'h13C; btn = 3'b101;
      snap();
      spi_frame(8'h83, 40, -1, '0, -1, got, bm);
      check("nom_data", 64'(got[47:8]), 64'hA5_02_3C_01_05);
      check("nom_busy", 64'(bm), 64'd1);
      check("nom_led", 64'(led_cmd), 64'd3);
      check("nom_cmd_pulses", 64'(n_cmd - c0), 64'd1);
      check("nom_done", 64'(n_done - d0), 64'd1);
      check("nom_err", 64'(n_err - e0), 64'd0);

      // Non-command byte 0
      snap();
      spi_frame(8'h40, 40, -1, '0, -1, got, bm);
      check("noncmd_data", 64'(got[47:8]), 64'hA5_02_3C_01_05);
      check("noncmd_led", 64'(led_cmd), 64'd3);
      check("noncmd_cmd_pulses", 64'(n_cmd - c0), 64'd0);
      check("noncmd_done", 64'(n_done - d0), 64'd1);
      check("noncmd_err", 64'(n_err - e0), 64'd0);

      // Short frame, then a full one
      snap();
      spi_frame(8'h00, 24, -1, '0, -1, got, bm);
      check("short_data", 64'(got[47:24]), 64'hA5_02_3C);
      check("short_err", 64'(n_err - e0), 64'd1);
      check("short_done", 64'(n_done - d0), 64'd0);
      snap();
      spi_frame(8'h00, 40, -1, '0, -1, got, bm);
      check("after_short_data", 64'(got[47:8]), 64'hA5_02_3C_01_05);
      check("after_short_done", 64'(n_done - d0), 64'd1);

      // x_pos changes during byte 2
      x_pos = 10'h3FF;
      wait_clk(5);
      spi_frame(8'h00, 40, 16, 10'h000, -1, got, bm);
      check("midchg_data", 64'(got[47:8]), 64'hFF_03_3C_01_05);
      spi_frame(8'h00, 40, -1, '0, -1, got, bm);
      check("midchg_next_data", 64'(got[47:8]), 64'h00_00_3C_01_05);

      // Reset at bit 15 with SS low
      x_pos = 10'h2A5;
      wait_clk(5);
      snap();
      spi_frame(8'h00, 40, -1, '0, 15, got, bm);
      check("rst_mid_tail", 64'(got[32:0]), 64'd0);
      check("rst_mid_done", 64'(n_done - d0), 64'd0);
      check("rst_mid_err", 64'(n_err - e0), 64'd0);
      check("rst_mid_cmd", 64'(n_cmd - c0), 64'd0);
      snap();
      spi_frame(8'h83, 40, -1, '0, -1, got, bm);
      check("after_rst_data", 64'(got[47:8]), 64'hA5_02_3C_01_05);
      check("after_rst_done", 64'(n_done - d0), 64'd1);
      check("after_rst_led", 64'(led_cmd), 64'd3);

      // Overlong frame of 48 bits
      snap();
      spi_frame(8'h00, 48, -1, '0, -1, got, bm);
      check("long_data", 64'(got[47:8]), 64'hA5_02_3C_01_05);
      check("long_tail", 64'(got[7:0]), 64'd0);
      check("long_err", 64'(n_err - e0), 64'd1);
      check("long_done", 64'(n_done - d0), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
